// File: rtl/oled_pkg.sv
// Shared types and constants for the OLED command path: command buffer type,
// transmitter state encoding and the length clamp used when a sequence is latched.
package oled_pkg;

  localparam int MAX_CMD_BYTES = 11;
  localparam logic [7:0] CMD_DRAW_RECT = 8'h22;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } tx_state_t;

  typedef logic [7:0] cmd_array_t [0:MAX_CMD_BYTES-1];

  function automatic logic [3:0] clamp_len(input logic [3:0] len, input int max_len);
    if (int'(len) > max_len) return 4'(max_len);
    return len;
  endfunction

endpackage

// File: rtl/oled_spi_byte_shifter.sv
// One-byte SPI mode-0 serialiser: CLK_DIV-cycle low/high phases per bit, MSB first.
// byte_done is combinational and marks the last cycle of bit 0's high phase.
module oled_spi_byte_shifter #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_byte,
  output logic       sclk,
  output logic       mosi,
  output logic       byte_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt_q;
  logic          phase_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    sreg_q;

  assign sclk      = phase_q;
  assign mosi      = sreg_q[7];
  assign byte_done = en && (div_cnt_q == '0) && phase_q && (bit_cnt_q == 3'd0);

  // A load always restarts a byte on a fresh low phase, even mid-stream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= DIV_LAST;
      phase_q   <= 1'b0;
      bit_cnt_q <= 3'd7;
      sreg_q    <= 8'h00;
    end else if (load) begin
      div_cnt_q <= DIV_LAST;
      phase_q   <= 1'b0;
      bit_cnt_q <= 3'd7;
      sreg_q    <= load_byte;
    end else if (!en) begin
      div_cnt_q <= DIV_LAST;
      phase_q   <= 1'b0;
    end else if (div_cnt_q == '0) begin
      div_cnt_q <= DIV_LAST;
      phase_q   <= ~phase_q;
      if (phase_q) begin
        sreg_q    <= {sreg_q[6:0], 1'b0};
        bit_cnt_q <= bit_cnt_q - 3'd1;
      end
    end else begin
      div_cnt_q <= div_cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/oled_cmd_spi_tx.sv
// Sends a latched OLED command sequence (all bytes in command mode) over 4-wire SPI
// and pulses done once chip select has been held through the trailing hold time.
module oled_cmd_spi_tx
  import oled_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] cmd_len,
  input  cmd_array_t cmd_bytes,
  output logic       busy,
  output logic       done,
  output logic       spi_sclk,
  output logic       spi_mosi,
  output logic       spi_cs_n,
  output logic       spi_dc
);

  // state  | meaning
  // IDLE   | waiting for start, CS high, DC high
  // SHIFT  | serialising byte byte_idx_q of the latched buffer
  // FINISH | SCLK low, CS held low for CLK_DIV cycles before release

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  tx_state_t     state_q, state_d;
  cmd_array_t    bytes_q;
  logic [3:0]    len_q;
  logic [3:0]    byte_idx_q;
  logic [3:0]    next_idx;
  logic [CW-1:0] fin_cnt_q;
  logic          done_q, done_d;

  logic          accept;
  logic          last_byte;
  logic          advance;
  logic          sh_load;
  logic [7:0]    sh_byte;
  logic          sh_sclk, sh_mosi, sh_byte_done;

  assign accept    = (state_q == IDLE) && start && (cmd_len != 4'd0);
  assign last_byte = (byte_idx_q == (len_q - 4'd1));
  assign next_idx  = byte_idx_q + 4'd1;
  assign advance   = (state_q == SHIFT) && sh_byte_done && !last_byte;

  always_comb begin
    state_d = state_q;
    sh_load = 1'b0;
    sh_byte = cmd_bytes[0];
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          sh_load = 1'b1;
        end
      end
      SHIFT: begin
        if (sh_byte_done) begin
          if (last_byte) begin
            state_d = FINISH;
          end else begin
            sh_load = 1'b1;
            sh_byte = bytes_q[next_idx];
          end
        end
      end
      FINISH: begin
        if (fin_cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_CMD_BYTES; i++) bytes_q[i] <= 8'h00;
      len_q      <= 4'd0;
      byte_idx_q <= 4'd0;
    end else if (accept) begin
      bytes_q    <= cmd_bytes;
      len_q      <= clamp_len(cmd_len, MAX_BYTES);
      byte_idx_q <= 4'd0;
    end else if (advance) begin
      byte_idx_q <= next_idx;
    end
  end

  // Hold-time counter is parked at full count outside FINISH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_cnt_q <= DIV_LAST;
    end else if (state_q != FINISH) begin
      fin_cnt_q <= DIV_LAST;
    end else if (fin_cnt_q != '0) begin
      fin_cnt_q <= fin_cnt_q - 1'b1;
    end
  end

  oled_spi_byte_shifter #(
    .CLK_DIV(CLK_DIV)
  ) u_shifter (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (state_q == SHIFT),
    .load     (sh_load),
    .load_byte(sh_byte),
    .sclk     (sh_sclk),
    .mosi     (sh_mosi),
    .byte_done(sh_byte_done)
  );

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign spi_sclk = sh_sclk;
  assign spi_mosi = busy & sh_mosi;
  assign spi_cs_n = (state_q == IDLE);
  assign spi_dc   = (state_q == IDLE);

endmodule

// File: tb/tb_oled_cmd_spi_tx.sv
// Directed bench for oled_cmd_spi_tx: two instances (CLK_DIV 4 and 1) share stimulus,
// a monitor decodes the SPI bus of the selected instance into bytes.
module tb_oled_cmd_spi_tx;
  import oled_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] cmd_len = 4'd0;
  cmd_array_t cmd;

  logic a_busy, a_done, a_sclk, a_mosi, a_cs_n, a_dc;
  logic b_busy, b_done, b_sclk, b_mosi, b_cs_n, b_dc;
  logic m_busy, m_done, m_sclk, m_mosi, m_cs_n, m_dc;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  oled_cmd_spi_tx #(.CLK_DIV(4), .MAX_BYTES(11)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .cmd_len(cmd_len), .cmd_bytes(cmd),
    .busy(a_busy), .done(a_done), .spi_sclk(a_sclk), .spi_mosi(a_mosi),
    .spi_cs_n(a_cs_n), .spi_dc(a_dc));

  oled_cmd_spi_tx #(.CLK_DIV(1), .MAX_BYTES(11)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .cmd_len(cmd_len), .cmd_bytes(cmd),
    .busy(b_busy), .done(b_done), .spi_sclk(b_sclk), .spi_mosi(b_mosi),
    .spi_cs_n(b_cs_n), .spi_dc(b_dc));

  assign m_busy = sel ? b_busy : a_busy;
  assign m_done = sel ? b_done : a_done;
  assign m_sclk = sel ? b_sclk : a_sclk;
  assign m_mosi = sel ? b_mosi : a_mosi;
  assign m_cs_n = sel ? b_cs_n : a_cs_n;
  assign m_dc   = sel ? b_dc   : a_dc;

  // SPI monitor, sampling 1 time unit after each rising clk edge.
  logic [7:0] cap[$];
  logic [7:0] shreg = 8'h00;
  int bitc = 0, rises = 0, dc_err = 0, done_cnt = 0, busy_cnt = 0, cs_low_cnt = 0;
  int hi_run = 0, last_gap = 0;
  logic prev_sclk = 1'b0, prev_cs = 1'b1;

  always @(posedge clk) begin
    #1;
    if (m_sclk && !prev_sclk) begin
      rises++;
      if (m_dc !== 1'b0) dc_err++;
      shreg = {shreg[6:0], m_mosi};
      bitc++;
      if (bitc == 8) begin
        cap.push_back(shreg);
        bitc = 0;
      end
    end
    if (m_cs_n) begin
      bitc = 0;
      hi_run++;
    end else begin
      if (prev_cs) last_gap = hi_run;
      hi_run = 0;
      cs_low_cnt++;
    end
    if (m_done) done_cnt++;
    if (m_busy) busy_cnt++;
    prev_sclk = m_sclk;
    prev_cs   = m_cs_n;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic mon_clear();
    cap.delete();
    rises = 0; dc_err = 0; done_cnt = 0; busy_cnt = 0; cs_low_cnt = 0;
  endtask

  task automatic start_xfer(input logic [3:0] len);
    cmd_len = len;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int limit, output int n);
    n = n0;
    while (!m_done && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    tests++; if (a_busy !== 1'b0 || b_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got a=%b b=%b exp 0", a_busy, b_busy); end
    tests++; if (a_done !== 1'b0 || b_done !== 1'b0) begin fails++; $display("FAIL reset_done got a=%b b=%b exp 0", a_done, b_done); end
    tests++; if (a_sclk !== 1'b0 || a_mosi !== 1'b0) begin fails++; $display("FAIL reset_sclk_mosi got %b%b exp 00", a_sclk, a_mosi); end
    tests++; if (a_cs_n !== 1'b1 || b_cs_n !== 1'b1) begin fails++; $display("FAIL reset_cs_n got a=%b b=%b exp 1", a_cs_n, b_cs_n); end
    tests++; if (a_dc !== 1'b1 || b_dc !== 1'b1) begin fails++; $display("FAIL reset_dc got a=%b b=%b exp 1", a_dc, b_dc); end
  endtask

  task automatic test_rect();
    logic [7:0] exp_b [0:10] = '{8'h22, 8'h00, 8'h10, 8'h2F, 8'h2F, 8'h00, 8'h3F, 8'h3E, 8'h00, 8'h3F, 8'h3E};
    int n;
    sel = 1'b0;
    for (int i = 0; i < 11; i++) cmd[i] = exp_b[i];
    mon_clear();
    start_xfer(4'd11);
    tests++; if (m_busy !== 1'b1 || m_cs_n !== 1'b0 || m_dc !== 1'b0 || m_sclk !== 1'b0)
      begin fails++; $display("FAIL rect_first_cycle got busy=%b cs_n=%b dc=%b sclk=%b exp 1 0 0 0", m_busy, m_cs_n, m_dc, m_sclk); end
    tests++; if (m_mosi !== 1'b0) begin fails++; $display("FAIL rect_first_mosi got %b exp 0", m_mosi); end
    wait_done(1, 900, n);
    tests++; if (n != 709) begin fails++; $display("FAIL rect_done_latency got %0d exp 709", n); end
    tests++; if (m_busy !== 1'b0 || m_cs_n !== 1'b1 || m_dc !== 1'b1)
      begin fails++; $display("FAIL rect_done_cycle got busy=%b cs_n=%b dc=%b exp 0 1 1", m_busy, m_cs_n, m_dc); end
    step();
    tests++; if (cap.size() != 11) begin fails++; $display("FAIL rect_byte_count got %0d exp 11", cap.size()); end
    for (int i = 0; i < 11 && i < cap.size(); i++) begin
      tests++; if (cap[i] !== exp_b[i]) begin fails++; $display("FAIL rect_byte%0d got %h exp %h", i, cap[i], exp_b[i]); end
    end
    tests++; if (dc_err != 0 || rises != 88) begin fails++; $display("FAIL rect_sclk got rises=%0d dc_err=%0d exp 88 0", rises, dc_err); end
    tests++; if (done_cnt != 1) begin fails++; $display("FAIL rect_done_pulses got %0d exp 1", done_cnt); end
  endtask

  task automatic test_single();
    int n;
    sel = 1'b1;
    cmd[0] = 8'hA5;
    mon_clear();
    start_xfer(4'd1);
    tests++; if (m_mosi !== 1'b1) begin fails++; $display("FAIL single_first_mosi got %b exp 1", m_mosi); end
    wait_done(1, 100, n);
    tests++; if (n != 18) begin fails++; $display("FAIL single_done_latency got %0d exp 18", n); end
    step();
    tests++; if (rises != 8) begin fails++; $display("FAIL single_rises got %0d exp 8", rises); end
    tests++; if (cap.size() != 1 || cap[0] !== 8'hA5) begin fails++; $display("FAIL single_byte got n=%0d b=%h exp 1 a5", cap.size(), (cap.size() > 0) ? cap[0] : 8'hxx); end
  endtask

  task automatic test_len_zero();
    sel = 1'b1;
    mon_clear();
    start_xfer(4'd0);
    repeat (20) step();
    tests++; if (busy_cnt != 0 || cs_low_cnt != 0 || done_cnt != 0)
      begin fails++; $display("FAIL len_zero got busy=%0d cs_low=%0d done=%0d exp 0 0 0", busy_cnt, cs_low_cnt, done_cnt); end
  endtask

  task automatic test_len_clamp();
    int n;
    sel = 1'b1;
    for (int i = 0; i < 11; i++) cmd[i] = 8'(8'h11 * (i + 1));
    mon_clear();
    start_xfer(4'd15);
    wait_done(1, 400, n);
    tests++; if (n != 178) begin fails++; $display("FAIL clamp_done_latency got %0d exp 178", n); end
    step();
    tests++; if (cap.size() != 11) begin fails++; $display("FAIL clamp_byte_count got %0d exp 11", cap.size()); end
    for (int i = 0; i < 11 && i < cap.size(); i++) begin
      tests++; if (cap[i] !== 8'(8'h11 * (i + 1))) begin fails++; $display("FAIL clamp_byte%0d got %h exp %h", i, cap[i], 8'(8'h11 * (i + 1))); end
    end
  endtask

  task automatic test_ignore_busy();
    int n;
    logic [7:0] exp_b [0:2] = '{8'h81, 8'h42, 8'h18};
    sel = 1'b1;
    for (int i = 0; i < 3; i++) cmd[i] = exp_b[i];
    mon_clear();
    start_xfer(4'd3);
    repeat (9) step();
    for (int i = 0; i < 11; i++) cmd[i] = 8'hFF;
    start_xfer(4'd1);
    wait_done(11, 200, n);
    tests++; if (n != 50) begin fails++; $display("FAIL ignore_done_latency got %0d exp 50", n); end
    repeat (60) step();
    tests++; if (cap.size() != 3 || done_cnt != 1) begin fails++; $display("FAIL ignore_counts got bytes=%0d done=%0d exp 3 1", cap.size(), done_cnt); end
    for (int i = 0; i < 3 && i < cap.size(); i++) begin
      tests++; if (cap[i] !== exp_b[i]) begin fails++; $display("FAIL ignore_byte%0d got %h exp %h", i, cap[i], exp_b[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [7:0] exp_b [0:2] = '{8'h5A, 8'hC3, 8'h96};
    sel = 1'b1;
    cmd[0] = 8'h5A; cmd[1] = 8'hC3;
    mon_clear();
    start_xfer(4'd2);
    wait_done(1, 100, n);
    tests++; if (n != 34) begin fails++; $display("FAIL b2b_first_latency got %0d exp 34", n); end
    cmd[0] = 8'h96;
    start_xfer(4'd1);
    tests++; if (m_cs_n !== 1'b0 || m_busy !== 1'b1) begin fails++; $display("FAIL b2b_restart got cs_n=%b busy=%b exp 0 1", m_cs_n, m_busy); end
    wait_done(1, 100, n);
    tests++; if (n != 18) begin fails++; $display("FAIL b2b_second_latency got %0d exp 18", n); end
    step();
    tests++; if (last_gap != 1) begin fails++; $display("FAIL b2b_cs_gap got %0d exp 1", last_gap); end
    tests++; if (cap.size() != 3 || done_cnt != 2) begin fails++; $display("FAIL b2b_counts got bytes=%0d done=%0d exp 3 2", cap.size(), done_cnt); end
    for (int i = 0; i < 3 && i < cap.size(); i++) begin
      tests++; if (cap[i] !== exp_b[i]) begin fails++; $display("FAIL b2b_byte%0d got %h exp %h", i, cap[i], exp_b[i]); end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    sel = 1'b0;
    for (int i = 0; i < 5; i++) cmd[i] = 8'(8'hA0 + i);
    mon_clear();
    start_xfer(4'd5);
    repeat (199) step();
    tests++; if (m_busy !== 1'b1 || cap.size() != 3) begin fails++; $display("FAIL rstmid_progress got busy=%b bytes=%0d exp 1 3", m_busy, cap.size()); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (m_cs_n !== 1'b1 || m_sclk !== 1'b0 || m_busy !== 1'b0 || m_mosi !== 1'b0 || m_dc !== 1'b1)
      begin fails++; $display("FAIL rstmid_outputs got cs_n=%b sclk=%b busy=%b mosi=%b dc=%b exp 1 0 0 0 1", m_cs_n, m_sclk, m_busy, m_mosi, m_dc); end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();
    tests++; if (done_cnt != 0 || m_busy !== 1'b0) begin fails++; $display("FAIL rstmid_no_done got done=%0d busy=%b exp 0 0", done_cnt, m_busy); end
    cmd[0] = 8'h3C;
    mon_clear();
    start_xfer(4'd1);
    wait_done(1, 200, n);
    tests++; if (n != 69) begin fails++; $display("FAIL rstmid_post_latency got %0d exp 69", n); end
    step();
    tests++; if (cap.size() != 1 || cap[0] !== 8'h3C) begin fails++; $display("FAIL rstmid_post_byte got n=%0d b=%h exp 1 3c", cap.size(), (cap.size() > 0) ? cap[0] : 8'hxx); end
  endtask

  initial begin
    for (int i = 0; i < 11; i++) cmd[i] = 8'h00;
    #23;
    test_reset();
    rst_n = 1'b1;
    repeat (3) step();
    test_rect();
    test_single();
    test_len_zero();
    test_len_clamp();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/oled_cmd_spi_tx.md
# oled_cmd_spi_tx

Serialises a latched OLED command sequence of up to 11 bytes onto the display's 4-wire SPI bus. It sits between the rectangle/colour command generators and the SSD1331-class OLED panel. Every byte is sent in command mode (D/C low), and `done` pulses when the whole sequence has been sent.

## Interface
- `CLK_DIV`, default 4: SCLK half-period in `clk` cycles; legal range ≥1.
- `MAX_BYTES`, default 11: capacity of the command buffer.
- `clk`, in, 1: system clock; all logic is rising-edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request pulse; sampled only in IDLE.
- `cmd_len`, in, 4: number of bytes to send; 0 means ignore, values >11 are clamped to 11.
- `cmd_bytes`, in, 11×8 (unpacked `[0:10]`): byte 0 is sent first; latched on an accepted `start`.
- `busy`, out, 1: high from the cycle after acceptance through FINISH.
- `done`, out, 1: one-cycle pulse at completion.
- `spi_sclk`, out, 1: SPI clock; idles low.
- `spi_mosi`, out, 1: serial data, MSB first.
- `spi_cs_n`, out, 1: chip select, active low.
- `spi_dc`, out, 1: data/command select; held 0 (command) for the whole sequence.

## Operation
- SPI mode 0: MOSI changes while SCLK is low; the panel samples on the SCLK rising edge.
- FSM states:
  - IDLE → SHIFT when `start && cmd_len!=0`. On that edge it latches the bytes, `len = min(cmd_len, 11)`, byte index 0, bit index 7.
  - SHIFT: each bit is a low phase of `CLK_DIV` cycles followed by a high phase of `CLK_DIV` cycles.
    - At the end of the high phase, the bit index decrements.
    - After bit 0, the byte index increments and the bit index reloads to 7.
    - After bit 0 of byte `len-1`, go to FINISH.
  - FINISH: SCLK low and CS held low for `CLK_DIV` cycles (hold time), then → IDLE with `done`=1 for one cycle.
- `start` while busy is ignored; no queueing.
- Changes on `cmd_bytes` or `cmd_len` while busy have no effect, because both were latched.
- `spi_mosi` = current bit while busy, 0 in IDLE.
- Reset, including mid-transfer: every output goes to its reset value immediately. A partial transfer is abandoned and no `done` is produced.
- Reset values: `busy`=0, `done`=0, `spi_sclk`=0, `spi_mosi`=0, `spi_cs_n`=1, `spi_dc`=1.

## Timing
- `start` is sampled at edge T. At T+1: `busy`=1, `spi_cs_n`=0, `spi_dc`=0, `spi_mosi` = bit 7 of byte 0, SCLK low.
- Bit k occupies `2*CLK_DIV` cycles, and SCLK rises at the midpoint of each bit.
- Total bit phase: `16*CLK_DIV*len` cycles (T+1 … T+16·CLK_DIV·len).
- FINISH: the next `CLK_DIV` cycles.
- At T+1+16·CLK_DIV·len+CLK_DIV: `done`=1, `busy`=0, `spi_cs_n`=1, `spi_dc`=1.
- A new `start` is accepted in the same cycle `done` is high; that transfer's CS falls one cycle later, giving a CS-high gap of ≥1 cycle.
- Worked latency, `CLK_DIV`=4 and `len`=11: `done` at T+709.

## Structure
- Package `oled_pkg` holds:
  - `MAX_CMD_BYTES`=11
  - `CMD_DRAW_RECT`=8'h22
  - the state enum `tx_state_t {IDLE, SHIFT, FINISH}`
  - a typedef for the 11-byte command array, shared with the command generators.
- Sub-module `oled_spi_byte_shifter`:
  - contains the `CLK_DIV` phase counter plus the 8-bit MSB-first shift register with SCLK generation;
  - it raises `byte_done` at the end of bit 0.
- The top block owns the FSM, byte index, latching and `done`.

## Test plan
- Rectangle command, `CLK_DIV`=4, `len`=11, bytes 22 00 10 2F 2F 00 3F 3E 00 3F 3E (yellow, y=47). The SPI monitor must capture exactly these 11 bytes, with DC=0 on every SCLK rise, and `done` at T+709.
- Single byte 8'hA5, `len`=1, `CLK_DIV`=1. Required response:
  - MOSI sampled on the rising edges reads 1,0,1,0,0,1,0,1;
  - exactly 8 SCLK rises;
  - `done` at T+18.
- `cmd_len`=0 → no `busy`, CS stays high, no `done`. `cmd_len`=15 → 11 bytes sent.
- `start` pulsed again mid-transfer while `cmd_bytes` is changed → the original bytes are sent unchanged, and no second transfer follows.
- Back-to-back: `start` in the `done` cycle → the second transfer begins, CS is high for exactly 1 cycle between transfers, and both byte streams are correct.
- `rst_n` asserted during byte 3 → same cycle: CS=1, SCLK=0, `busy`=0, and no `done`. A post-reset transfer of 8'h3C completes correctly.
